// File: rtl/csa_serial_add_ctrl.sv
// Multi-cycle WIDTH-bit adder. It processes one nibble per clock through a single
// 4-bit carry-select slice and uses valid/ready handshakes on the operand and result sides.

module Carry_Select_Adder_4bits (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [4:0] sum0;
  logic [4:0] sum1;

  // Both carry-in cases are computed up front. Cin only selects between them.
  always_comb begin
    sum0 = {1'b0, A} + {1'b0, B};
    sum1 = sum0 + 5'd1;
    S    = Cin ? sum1[3:0] : sum0[3:0];
    Cout = Cin ? sum1[4]   : sum0[4];
  end

endmodule

module csa_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              carry_q, carry_d;
  logic              v_q, v_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [3:0]        nib_a, nib_b, nib_s;
  logic              nib_c;

  assign nib_a = a_q[4*idx_q +: 4];
  assign nib_b = b_q[4*idx_q +: 4];

  Carry_Select_Adder_4bits u_slice (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_q),
    .S    (nib_s),
    .Cout (nib_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    v_d     = v_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          s_d[4*idx_q +: 4] = nib_s;
          carry_d           = nib_c;
          if (idx_q == IDXW'(NIB - 1)) begin
            // The result MSB is still being written on this edge, so it comes from the slice.
            v_d     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (flush || out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      v_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      v_q     <= v_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign S         = s_q;
  assign Cout      = carry_q;
  assign V         = v_q;

endmodule

// File: tb/tb_csa_serial_add_ctrl.sv
// Bench for csa_serial_add_ctrl. It compares the DUT against an arithmetic reference model
// on every cycle and also pins a set of hand-computed results.

module tb_csa_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;
  logic             busy;

  int checks = 0;
  int errors = 0;

  csa_serial_add_ctrl #(.WIDTH(WIDTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .V         (V),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation is pending for NIB edges and then offers its result.
  bit               m_pend;
  int               m_cnt;
  logic [WIDTH-1:0] m_s;
  logic             m_c;
  logic             m_v;

  initial begin
    m_pend = 1'b0;
    m_cnt  = 0;
    m_s    = '0;
    m_c    = 1'b0;
    m_v    = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n || flush) begin
        m_pend = 1'b0;
      end else if (!m_pend) begin
        if (in_valid) begin
          m_pend = 1'b1;
          m_cnt  = 0;
          {m_c, m_s} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
          m_v = (A[WIDTH-1] == B[WIDTH-1]) && (m_s[WIDTH-1] != A[WIDTH-1]);
        end
      end else if (m_cnt < NIB) begin
        m_cnt++;
      end else if (out_ready) begin
        m_pend = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_S", S, 0);
        chk("rst_Cout", Cout, 0);
        chk("rst_V", V, 0);
      end else begin
        chk("in_ready", in_ready, !m_pend);
        chk("busy", busy, m_pend);
        chk("out_valid", out_valid, m_pend && (m_cnt == NIB));
        if (m_pend && m_cnt == NIB) begin
          chk("S", S, m_s);
          chk("Cout", Cout, m_c);
          chk("V", V, m_v);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                        input int hold, input logic [WIDTH-1:0] es, input logic ec,
                        input logic ev, input string tag);
    int n;
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    Cin       = c;
    out_ready = 1'b0;
    chk({tag, "_ready_pre"}, in_ready, 1);
    cyc();
    in_valid = 1'b0;
    A        = 16'hAAAA;
    B        = 16'hAAAA;
    Cin      = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_latency"}, n, NIB);
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_S"}, S, es);
    end
    chk({tag, "_S"}, S, es);
    chk({tag, "_Cout"}, Cout, ec);
    chk({tag, "_V"}, V, ev);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_ready"}, in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();

    run_op(16'h5656, 16'h6565, 1'b0, 0, 16'hBBBB, 1'b0, 1'b1, "basic");
    cyc();
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0, "carry");
    cyc();
    run_op(16'h0000, 16'h0000, 1'b1, 0, 16'h0001, 1'b0, 1'b0, "cin");
    cyc();
    run_op(16'h0005, 16'h0006, 1'b0, 5, 16'h000B, 1'b0, 1'b0, "bp");
    cyc();
    run_op(16'h1234, 16'h1111, 1'b0, 0, 16'h2345, 1'b0, 1'b0, "capture");
    cyc();

    // Flush while the third nibble is in progress, with a competing operand request.
    in_valid = 1'b1;
    A = 16'h4444;
    B = 16'h4444;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    flush    = 1'b1;
    in_valid = 1'b1;
    A = 16'h0001;
    B = 16'h0001;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_valid", out_valid, 0);
    cyc();
    chk("flush_noaccept", busy, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1, "postflush");
    cyc();

    in_valid = 1'b1;
    A = 16'h1234;
    B = 16'h4321;
    cyc();
    in_valid = 1'b0;
    cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_ready", in_ready, 1);
    chk("async_busy", busy, 0);
    chk("async_S", S, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();
    run_op(16'h00FF, 16'h0F01, 1'b0, 1, 16'h1000, 1'b0, 1'b0, "postrst");

    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      A         = WIDTH'($urandom);
      B         = WIDTH'($urandom);
      Cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cyc();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (NIB + 3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
